// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles framed player commands from the UART byte stream,
// verifies the xor checksum and hands each good command to the player control
// logic over a valid/ready handshake. Malformed frames, inter-byte timeouts
// and bytes arriving while a command is still held are flagged on FRAME_ERR.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER  = 8'hAA,
    parameter int         MAX_LEN = 4,
    parameter int         TIMEOUT = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RXD_OVER,
    input  logic [7:0]  RXD_DATA,
    input  logic        CMD_READY,
    output logic        CMD_VALID,
    output logic [7:0]  CMD_CODE,
    output logic [2:0]  CMD_LEN,
    output logic [31:0] CMD_ARG,
    output logic        FRAME_ERR,
    output logic [1:0]  ERR_CODE
);

    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]     LEN_MAX = 8'(MAX_LEN);

    localparam logic [1:0] E_OVERRUN  = 2'd0;
    localparam logic [1:0] E_CHECKSUM = 2'd1;
    localparam logic [1:0] E_BAD_LEN  = 2'd2;
    localparam logic [1:0] E_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_HDR, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD
    } state_t;

    state_t state, state_nxt;

    // Shadow registers for the frame under assembly; the visible command
    // outputs are only loaded from these once the checksum has matched.
    logic [7:0]       code_sh;
    logic [2:0]       len_sh;
    logic [31:0]      arg_sh;
    logic [7:0]       xor_sh;
    logic [2:0]       idx;
    logic [CNT_W-1:0] to_cnt;

    logic in_frame, timeout_hit, pay_last, chk_ok;
    logic err_fire, load_cmd;
    logic [1:0] err_cause;

    assign in_frame    = (state == S_CMD) || (state == S_LEN) ||
                         (state == S_PAY) || (state == S_CHK);
    // A strobe in the expiry cycle wins, so timeout requires a quiet cycle.
    assign timeout_hit = in_frame && !RXD_OVER && (to_cnt == TO_LAST);
    assign pay_last    = (idx == len_sh - 3'd1);
    assign chk_ok      = (RXD_DATA == xor_sh);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!RST_N) state <= S_HDR;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_HDR:  if (RXD_OVER && RXD_DATA == HEADER) state_nxt = S_CMD;
            S_CMD:  if (RXD_OVER) state_nxt = S_LEN;
            S_LEN:  if (RXD_OVER) begin
                        if (RXD_DATA > LEN_MAX)    state_nxt = S_HDR;
                        else if (RXD_DATA == 8'd0) state_nxt = S_CHK;
                        else                       state_nxt = S_PAY;
                    end
            S_PAY:  if (RXD_OVER && pay_last) state_nxt = S_CHK;
            S_CHK:  if (RXD_OVER) state_nxt = chk_ok ? S_HOLD : S_HDR;
            S_HOLD: if (CMD_READY) state_nxt = S_HDR;
            default: state_nxt = S_HDR;
        endcase
        if (timeout_hit) state_nxt = S_HDR;
    end

    // Error detection and command-load decode for the current edge.
    always_comb begin
        err_fire  = 1'b0;
        err_cause = E_OVERRUN;
        load_cmd  = 1'b0;
        if (timeout_hit) begin
            err_fire  = 1'b1;
            err_cause = E_TIMEOUT;
        end else if (RXD_OVER) begin
            case (state)
                S_LEN:  if (RXD_DATA > LEN_MAX) begin
                            err_fire  = 1'b1;
                            err_cause = E_BAD_LEN;
                        end
                S_CHK:  if (chk_ok) load_cmd = 1'b1;
                        else begin
                            err_fire  = 1'b1;
                            err_cause = E_CHECKSUM;
                        end
                S_HOLD: begin
                            err_fire  = 1'b1;
                            err_cause = E_OVERRUN;
                        end
                default: ;
            endcase
        end
    end

    // Datapath: shadow assembly, timeout counter, command and error outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            code_sh   <= '0;
            len_sh    <= '0;
            arg_sh    <= '0;
            xor_sh    <= '0;
            idx       <= '0;
            to_cnt    <= '0;
            CMD_VALID <= 1'b0;
            CMD_CODE  <= '0;
            CMD_LEN   <= '0;
            CMD_ARG   <= '0;
            FRAME_ERR <= 1'b0;
            ERR_CODE  <= '0;
        end else begin
            FRAME_ERR <= err_fire;
            if (err_fire) ERR_CODE <= err_cause;

            if (in_frame && !RXD_OVER && !timeout_hit) to_cnt <= to_cnt + CNT_W'(1);
            else                                      to_cnt <= '0;

            if (RXD_OVER) begin
                case (state)
                    S_CMD: begin
                        code_sh <= RXD_DATA;
                        xor_sh  <= RXD_DATA;
                    end
                    S_LEN: begin
                        xor_sh <= xor_sh ^ RXD_DATA;
                        len_sh <= RXD_DATA[2:0];
                        arg_sh <= '0;
                        idx    <= '0;
                    end
                    S_PAY: begin
                        arg_sh[{idx[1:0], 3'b000} +: 8] <= RXD_DATA;
                        xor_sh <= xor_sh ^ RXD_DATA;
                        idx    <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end

            if (load_cmd) begin
                CMD_VALID <= 1'b1;
                CMD_CODE  <= code_sh;
                CMD_LEN   <= len_sh;
                CMD_ARG   <= arg_sh;
            end else if (state == S_HOLD && CMD_READY) begin
                CMD_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with TIMEOUT shortened to 64 cycles.
// Inputs change 1 ns after a rising edge; outputs are read at that point,
// i.e. they reflect the edge just taken.
module tb_uart_cmd_parser;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        RXD_OVER = 1'b0;
    logic [7:0]  RXD_DATA = 8'h00;
    logic        CMD_READY = 1'b0;
    logic        CMD_VALID;
    logic [7:0]  CMD_CODE;
    logic [2:0]  CMD_LEN;
    logic [31:0] CMD_ARG;
    logic        FRAME_ERR;
    logic [1:0]  ERR_CODE;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    uart_cmd_parser #(.HEADER(8'hAA), .MAX_LEN(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .RXD_OVER(RXD_OVER), .RXD_DATA(RXD_DATA),
        .CMD_READY(CMD_READY), .CMD_VALID(CMD_VALID), .CMD_CODE(CMD_CODE),
        .CMD_LEN(CMD_LEN), .CMD_ARG(CMD_ARG), .FRAME_ERR(FRAME_ERR),
        .ERR_CODE(ERR_CODE)
    );

    always #5 CLK = ~CLK;

    // Count every cycle in which the error pulse is high.
    always @(negedge CLK) if (FRAME_ERR === 1'b1) err_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RXD_OVER = 1'b1;
        RXD_DATA = b;
        tick();
        RXD_OVER = 1'b0;
        RXD_DATA = 8'h00;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG, FRAME_ERR, ERR_CODE} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b code=%h len=%0d arg=%h err=%b ec=%0d, required all 0",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG, FRAME_ERR, ERR_CODE);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        int e0 = err_cnt;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12);
        n_checks++;
        if (CMD_VALID !== 1'b0) begin
            n_fail++; $display("FAIL good_early_valid: got %b required 0", CMD_VALID);
        end
        send_byte(8'h25);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h01 || CMD_LEN !== 3'd2 || CMD_ARG !== 32'h00001234) begin
            n_fail++;
            $display("FAIL good_cmd: got v=%b code=%h len=%0d arg=%h, required v=1 code=01 len=2 arg=00001234",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
        n_checks++;
        if (CMD_VALID !== 1'b0) begin
            n_fail++; $display("FAIL good_accept: valid got %b required 0", CMD_VALID);
        end
        n_checks++;
        if (err_cnt != e0) begin
            n_fail++; $display("FAIL good_no_err: error pulses got %0d required 0", err_cnt - e0);
        end
    endtask

    task automatic test_zero_len_hold();
        int bad = 0;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h03 || CMD_LEN !== 3'd0 || CMD_ARG !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_cmd: got v=%b code=%h len=%0d arg=%h, required v=1 code=03 len=0 arg=0",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h03 || CMD_LEN !== 3'd0 || CMD_ARG !== 32'h0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL zero_hold_stable: unstable cycles got %0d required 0", bad);
        end
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
        n_checks++;
        if (CMD_VALID !== 1'b0) begin
            n_fail++; $display("FAIL zero_accept: valid got %b required 0", CMD_VALID);
        end
    endtask

    task automatic test_errors();
        int e0 = err_cnt;
        // Checksum: 01^01^55 = 55, but 00 is sent.
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
        n_checks++;
        if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'd1 || CMD_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_err: got err=%b ec=%0d v=%b, required err=1 ec=1 v=0", FRAME_ERR, ERR_CODE, CMD_VALID);
        end
        tick();
        n_checks++;
        if (FRAME_ERR !== 1'b0 || ERR_CODE !== 2'd1) begin
            n_fail++; $display("FAIL chk_pulse_width: got err=%b ec=%0d, required err=0 ec=1", FRAME_ERR, ERR_CODE);
        end
        // Length 5 exceeds MAX_LEN.
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h05);
        n_checks++;
        if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'd2) begin
            n_fail++; $display("FAIL len_err: got err=%b ec=%0d, required err=1 ec=2", FRAME_ERR, ERR_CODE);
        end
        tick(); tick(); tick();
        n_checks++;
        if (FRAME_ERR !== 1'b0 || ERR_CODE !== 2'd2) begin
            n_fail++; $display("FAIL len_code_hold: got err=%b ec=%0d, required err=0 ec=2", FRAME_ERR, ERR_CODE);
        end
        // Garbage is dropped, then a good frame.
        send_byte(8'h13); send_byte(8'h37);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h25);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h01 || CMD_LEN !== 3'd2 || CMD_ARG !== 32'h00001234) begin
            n_fail++;
            $display("FAIL garbage_then_good: got v=%b code=%h len=%0d arg=%h, required v=1 code=01 len=2 arg=00001234",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
        n_checks++;
        if (err_cnt - e0 != 2) begin
            n_fail++; $display("FAIL err_pulse_count: got %0d required 2", err_cnt - e0);
        end
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
    endtask

    task automatic test_timeout();
        int early = 0;
        send_byte(8'hAA); send_byte(8'h02);
        // The 02 edge clears the counter; 63 quiet edges follow without error.
        for (int i = 1; i < 64; i++) begin
            tick();
            if (FRAME_ERR !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++; $display("FAIL timeout_early: error cycles got %0d required 0", early);
        end
        tick();
        n_checks++;
        if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'd3) begin
            n_fail++; $display("FAIL timeout_fire: got err=%b ec=%0d, required err=1 ec=3", FRAME_ERR, ERR_CODE);
        end
        tick();
        n_checks++;
        if (FRAME_ERR !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pulse_width: got %b required 0", FRAME_ERR);
        end
        // Same timing, but the LEN byte lands on the expiry edge and wins.
        send_byte(8'hAA); send_byte(8'h02);
        for (int i = 1; i < 64; i++) tick();
        send_byte(8'h01);
        n_checks++;
        if (FRAME_ERR !== 1'b0) begin
            n_fail++; $display("FAIL timeout_strobe_wins: err got %b required 0", FRAME_ERR);
        end
        send_byte(8'h09); send_byte(8'h0A);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h02 || CMD_LEN !== 3'd1 || CMD_ARG !== 32'h09) begin
            n_fail++;
            $display("FAIL timeout_late_frame: got v=%b code=%h len=%0d arg=%h, required v=1 code=02 len=1 arg=00000009",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
    endtask

    task automatic test_overrun();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h25);
        // Leave a different error code behind first so code 0 is observable.
        n_checks++;
        if (ERR_CODE !== 2'd3) begin
            n_fail++; $display("FAIL overrun_pre_code: ec got %0d required 3", ERR_CODE);
        end
        send_byte(8'h7E);
        n_checks++;
        if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'd0) begin
            n_fail++; $display("FAIL overrun_err: got err=%b ec=%0d, required err=1 ec=0", FRAME_ERR, ERR_CODE);
        end
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h01 || CMD_LEN !== 3'd2 || CMD_ARG !== 32'h00001234) begin
            n_fail++;
            $display("FAIL overrun_held: got v=%b code=%h len=%0d arg=%h, required v=1 code=01 len=2 arg=00001234",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
        tick();
        // Byte in the same cycle as the accepting handshake is an overrun too.
        CMD_READY = 1'b1;
        send_byte(8'h7E);
        CMD_READY = 1'b0;
        n_checks++;
        if (CMD_VALID !== 1'b0 || FRAME_ERR !== 1'b1 || ERR_CODE !== 2'd0) begin
            n_fail++;
            $display("FAIL overrun_on_accept: got v=%b err=%b ec=%0d, required v=0 err=1 ec=0", CMD_VALID, FRAME_ERR, ERR_CODE);
        end
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h02 || CMD_LEN !== 3'd1 || CMD_ARG !== 32'h09) begin
            n_fail++;
            $display("FAIL overrun_next_frame: got v=%b code=%h len=%0d arg=%h, required v=1 code=02 len=1 arg=00000009",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
    endtask

    task automatic test_back_to_back();
        // Command 02 is held on entry; HEADER follows the accept edge directly.
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h03 || CMD_LEN !== 3'd0 || CMD_ARG !== 32'h0 || FRAME_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cmd: got v=%b code=%h len=%0d arg=%h err=%b, required v=1 code=03 len=0 arg=0 err=0",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG, FRAME_ERR);
        end
        CMD_READY = 1'b1;
        tick();
        CMD_READY = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h05);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h04); send_byte(8'h11);
        RST_N = 1'b0;
        tick();
        n_checks++;
        if ({CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG, FRAME_ERR, ERR_CODE} !== 47'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b code=%h len=%0d arg=%h err=%b ec=%0d, required all 0",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG, FRAME_ERR, ERR_CODE);
        end
        RST_N = 1'b1;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
        n_checks++;
        if (CMD_VALID !== 1'b1 || CMD_CODE !== 8'h02 || CMD_LEN !== 3'd1 || CMD_ARG !== 32'h09) begin
            n_fail++;
            $display("FAIL midreset_frame: got v=%b code=%h len=%0d arg=%h, required v=1 code=02 len=1 arg=00000009",
                     CMD_VALID, CMD_CODE, CMD_LEN, CMD_ARG);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_len_hold();
        test_errors();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command-frame parser and sequencer that sits directly behind the UART byte receiver.
- Consumes the receiver's one-cycle byte strobe and data byte, assembles framed player commands (play/pause/track/volume), checks them, and presents each good command to the player control logic over a valid/ready handshake.
- Reports malformed frames, inter-byte timeouts and overruns.

Parameters:
- HEADER, 8'hAA, frame start byte.
- MAX_LEN, 4, maximum payload bytes (1..4).
- TIMEOUT, 100000, CLK cycles allowed between bytes inside a frame.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  synchronous, active-low reset.
- RXD_OVER  input  1  byte-received strobe, one CLK cycle wide.
- RXD_DATA  input  8  received byte; valid while RXD_OVER=1.
- CMD_READY  input  1  consumer accepts the current command.
- CMD_VALID  output  1  command available; held until accepted.
- CMD_CODE  output  8  command opcode.
- CMD_LEN  output  3  payload byte count.
- CMD_ARG  output  32  payload; byte k at [8k+7:8k], unused bytes zero.
- FRAME_ERR  output  1  one-cycle error pulse.
- ERR_CODE  output  2  cause of last error: 0 overrun, 1 checksum, 2 bad length, 3 timeout.

Behaviour:
- Reset: synchronous; RST_N=0 sampled at a CLK edge clears all state. All outputs go to 0 and the state goes to S_HDR. Reset mid-frame discards any partial frame.
- Frame format: HEADER, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ each payload byte.
- A byte is consumed at a CLK edge where RXD_OVER=1.
- States:
  - S_HDR: bytes other than HEADER are dropped silently. HEADER -> S_CMD.
  - S_CMD: latch the opcode; running xor = byte -> S_LEN.
  - S_LEN: if LEN > MAX_LEN, error code 2 and return to S_HDR. If LEN=0 -> S_CHK. Otherwise clear the payload shadow, set the byte index to 0 -> S_PAY.
  - S_PAY: store the byte at the current index, xor it in, increment the index. After the LEN-th byte -> S_CHK.
  - S_CHK: if the byte equals the running xor, load CMD_CODE/CMD_LEN/CMD_ARG from the shadow registers, set CMD_VALID -> S_HOLD. If not, error code 1 -> S_HDR.
  - S_HOLD: CMD_VALID=1 and outputs stay stable. On an edge with CMD_READY=1, CMD_VALID clears on the next cycle -> S_HDR.
- Latency: CMD_VALID rises on the cycle after the CHK strobe edge.
- Outputs CMD_CODE/LEN/ARG change only when CMD_VALID rises.
- Overrun: any byte strobe in S_HOLD is dropped with error code 0. This includes the byte in the same cycle as the accepting handshake. The command being held is unaffected.
- Timeout: in S_CMD, S_LEN, S_PAY and S_CHK, a counter clears on every strobe and increments otherwise. When it reaches TIMEOUT-1 with no strobe, error code 3 -> S_HDR. A strobe in that same cycle wins, so no timeout fires. The counter is idle in S_HDR and S_HOLD.
- Errors:
  - FRAME_ERR pulses high for exactly one cycle, on the cycle after the error edge.
  - ERR_CODE updates at the same time and holds until the next error.
  - Two error causes never occur in the same cycle, by state construction.
- Back-to-back frames with no gap are supported. The HEADER strobe may arrive on the cycle after the CMD_READY acceptance edge.

Test Plan:
- Good frame: AA 01 02 34 12 25 -> CMD_VALID=1 one cycle after the last strobe; CODE=01, LEN=2, ARG=32'h00001234; FRAME_ERR never asserts.
- Zero-length frame with ready low for 10 cycles: AA 03 00 03, CMD_READY held 0 then 1 -> CODE=03, LEN=0, ARG=0; VALID and outputs stable for 10 cycles, then VALID drops the cycle after acceptance.
- Checksum and length errors: AA 01 01 55 00 (expected 55) -> FRAME_ERR pulse, ERR_CODE=1, no VALID. Then AA 05 05 -> ERR_CODE=2. Then garbage 13 37 followed by a good frame -> garbage ignored, good command delivered.
- Timeout (TIMEOUT=64): AA 02, then silence -> FRAME_ERR with ERR_CODE=3 exactly 64 cycles after the 02 strobe. A byte arriving at cycle 63 instead -> no error.
- Overrun: command held with CMD_READY=0, byte 7E strobed -> ERR_CODE=0 pulse; held outputs unchanged; after acceptance, the next good frame is parsed normally.
- Reset mid-frame: AA 01 04 11, RST_N low for 1 cycle, then AA 02 01 09 0A -> partial frame discarded; CODE=02, LEN=1, ARG=32'h09; all outputs 0 during reset.
